// File: rtl/ge_pkg.sv
// ---------------------------------------------------------------------------
// ge_pkg
// Shared types and constants for the group-element units.
//   fe_t          : 320-bit signed field element, 10 packed 32-bit limbs,
//                   limb i in bits [32*i+31 : 32*i].
//   conv_state_t  : p1p1 conversion FSM states.
//   N_PROD_P2/P3  : number of field products per conversion mode.
//   limb_ext()    : one limb, sign-extended to 64 bits.
// ---------------------------------------------------------------------------
package ge_pkg;

    localparam int FE_LIMBS  = 10;
    localparam int N_PROD_P2 = 3;
    localparam int N_PROD_P3 = 4;

    typedef logic signed [319:0] fe_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        MUL_START  = 3'd2,
        MUL_WAIT   = 3'd3,
        DONE_STATE = 3'd4
    } conv_state_t;

    function automatic logic signed [63:0] limb_ext(input fe_t x, input int i);
        logic [31:0] l;
        l = x[32*i +: 32];
        return {{32{l[31]}}, l};
    endfunction

endpackage

// File: rtl/ge_p1p1_conv_if.sv
// ---------------------------------------------------------------------------
// ge_p1p1_conv_if
// Request/result bundle of the p1p1 -> p2/p3 converter.
//   start, to_p3, p_X..p_T : request side (master drives)
//   done, r_X..r_T         : result side (slave drives)
// ---------------------------------------------------------------------------
interface ge_p1p1_conv_if;
    import ge_pkg::*;

    logic start;
    logic to_p3;
    fe_t  p_X;
    fe_t  p_Y;
    fe_t  p_Z;
    fe_t  p_T;
    logic done;
    fe_t  r_X;
    fe_t  r_Y;
    fe_t  r_Z;
    fe_t  r_T;

    modport master (
        output start, to_p3, p_X, p_Y, p_Z, p_T,
        input  done, r_X, r_Y, r_Z, r_T
    );

    modport slave (
        input  start, to_p3, p_X, p_Y, p_Z, p_T,
        output done, r_X, r_Y, r_Z, r_T
    );

endinterface

// File: rtl/fe_mul.sv
// ---------------------------------------------------------------------------
// fe_mul
// Sequential field multiply h = f*g mod 2^255-19 on the 10-limb
// radix-2^25.5 representation, bit-exact with the reference fe_mul.
// One row of partial products (f_i times all g_j) is accumulated per
// cycle, then one cycle carries the 64-bit columns back to limb form.
// Latency: start sampled in cycle c, done pulses (one cycle) in c+12.
//   clk    : rising-edge clock
//   rst_n  : synchronous, active-low
//   start  : one-cycle request, ignored while busy
//   done   : one-cycle pulse, h valid from then until the next done
//   f, g   : operands, captured with start
//   h      : product
// ---------------------------------------------------------------------------
module fe_mul
    import ge_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done,
    input  fe_t  f,
    input  fe_t  g,
    output fe_t  h
);

    typedef logic signed [63:0] wide_t;
    typedef wide_t acc_t [FE_LIMBS];

    // Carry propagation order of the reference implementation; interleaving
    // the two halves keeps every column inside 64 bits.
    localparam int CARRY_ORDER [12] = '{0, 4, 1, 5, 2, 6, 3, 7, 4, 8, 9, 0};

    fe_t        f_q;
    fe_t        g_q;
    acc_t       acc;
    acc_t       acc_next;
    logic [3:0] row;
    logic       running;
    logic       finishing;

    // Even limbs hold 26 bits, odd limbs 25; the carry out of limb 9 wraps
    // to limb 0 with weight 19 (2^255 = 19 mod p).
    function automatic fe_t fe_carry(input acc_t a);
        acc_t  t;
        wide_t c;
        int    k;
        int    sh;
        fe_t   r;
        t = a;
        r = '0;
        for (int s = 0; s < 12; s++) begin
            k    = CARRY_ORDER[s];
            sh   = (k % 2 == 1) ? 25 : 26;
            c    = (t[k] + (64'sd1 <<< (sh - 1))) >>> sh;
            t[k] = t[k] - (c <<< sh);
            if (k == FE_LIMBS - 1) t[0] = t[0] + c * 64'sd19;
            else                   t[k + 1] = t[k + 1] + c;
        end
        for (int i = 0; i < FE_LIMBS; i++) r[32*i +: 32] = t[i][31:0];
        return r;
    endfunction

    // Row 'row' of the schoolbook product. Odd*odd terms are doubled
    // (half-bit radix); columns at or beyond 10 fold back with weight 19.
    always_comb begin
        wide_t fi;
        wide_t term;
        fi       = limb_ext(f_q, int'(row));
        acc_next = acc;
        for (int j = 0; j < FE_LIMBS; j++) begin
            term = fi * limb_ext(g_q, j);
            if (row[0] && (j % 2 == 1)) term = term <<< 1;
            if (int'(row) + j >= FE_LIMBS)
                acc_next[int'(row) + j - FE_LIMBS] = acc_next[int'(row) + j - FE_LIMBS] + term * 64'sd19;
            else
                acc_next[int'(row) + j] = acc_next[int'(row) + j] + term;
        end
    end

    // NOTE: only control flops are reset; the operand, accumulator and result
    // registers are always written before being read, so resetting them
    // would only add reset fan-out to wide datapath storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running   <= 1'b0;
            finishing <= 1'b0;
            done      <= 1'b0;
            row       <= '0;
        end else begin
            done <= 1'b0;
            if (running) begin
                acc <= acc_next;
                if (row == 4'(FE_LIMBS - 1)) begin
                    running   <= 1'b0;
                    finishing <= 1'b1;
                end else begin
                    row <= row + 4'd1;
                end
            end else if (finishing) begin
                h         <= fe_carry(acc);
                done      <= 1'b1;
                finishing <= 1'b0;
            end else if (start) begin
                f_q     <= f;
                g_q     <= g;
                row     <= '0;
                running <= 1'b1;
                for (int j = 0; j < FE_LIMBS; j++) acc[j] <= '0;
            end
        end
    end

endmodule

// File: rtl/ge_p1p1_conv.sv
// ---------------------------------------------------------------------------
// ge_p1p1_conv
// Converts a completed point (p1p1: X, Y, Z, T) to projective p2 (X, Y, Z)
// or extended p3 (X, Y, Z, T) using one shared sequential fe_mul:
//   idx 0: r_X = X*T   idx 1: r_Y = Y*Z   idx 2: r_Z = Z*T   idx 3: r_T = X*Y
// Products 0..2 always run; product 3 only in p3 mode. r_T is 0 in p2 mode.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears FSM, captures, outputs
//   bus   : slave side of ge_p1p1_conv_if
//           start  level request, sampled in IDLE
//           to_p3  mode select, captured with the inputs
//           done   high while results valid, until start drops
// ---------------------------------------------------------------------------
module ge_p1p1_conv
    import ge_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    ge_p1p1_conv_if.slave bus
);

    conv_state_t state;
    logic [1:0]  idx;
    logic [1:0]  last_idx;
    logic        mode;
    fe_t         c_x;
    fe_t         c_y;
    fe_t         c_z;
    fe_t         c_t;
    fe_t         r_x;
    fe_t         r_y;
    fe_t         r_z;
    fe_t         r_t;
    logic        done_q;
    logic        mul_start;
    logic        mul_done;
    fe_t         mul_f;
    fe_t         mul_g;
    fe_t         mul_h;

    assign last_idx = mode ? 2'(N_PROD_P3 - 1) : 2'(N_PROD_P2 - 1);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        mul_f = c_x;
        mul_g = c_t;
        case (idx)
            2'd0: begin mul_f = c_x; mul_g = c_t; end
            2'd1: begin mul_f = c_y; mul_g = c_z; end
            2'd2: begin mul_f = c_z; mul_g = c_t; end
            2'd3: begin mul_f = c_x; mul_g = c_y; end
            default: ;
        endcase
    end

    fe_mul u_fe_mul (
        .clk   (clk),
        .rst_n (~reset),
        .start (mul_start),
        .done  (mul_done),
        .f     (mul_f),
        .g     (mul_g),
        .h     (mul_h)
    );

    // NOTE: state and outputs use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            mode      <= 1'b0;
            c_x       <= '0;
            c_y       <= '0;
            c_z       <= '0;
            c_t       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_t       <= '0;
            done_q    <= 1'b0;
            mul_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) state <= LOAD;
                end
                LOAD: begin
                    c_x       <= bus.p_X;
                    c_y       <= bus.p_Y;
                    c_z       <= bus.p_Z;
                    c_t       <= bus.p_T;
                    mode      <= bus.to_p3;
                    idx       <= '0;
                    r_t       <= '0;
                    mul_start <= 1'b1;
                    state     <= MUL_START;
                end
                MUL_START: begin
                    mul_start <= 1'b0;
                    state     <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        case (idx)
                            2'd0: r_x <= mul_h;
                            2'd1: r_y <= mul_h;
                            2'd2: r_z <= mul_h;
                            2'd3: r_t <= mul_h;
                            default: ;
                        endcase
                        if (idx == last_idx) begin
                            done_q <= 1'b1;
                            state  <= DONE_STATE;
                        end else begin
                            idx       <= idx + 2'd1;
                            mul_start <= 1'b1;
                            state     <= MUL_START;
                        end
                    end
                end
                DONE_STATE: begin
                    // Held start does not retrigger; it must drop first.
                    if (!bus.start) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    done_q    <= 1'b0;
                    mul_start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.done = done_q;
    assign bus.r_X  = r_x;
    assign bus.r_Y  = r_y;
    assign bus.r_Z  = r_z;
    assign bus.r_T  = r_t;

endmodule
